// File: rtl/acc_ctrl_pkg.sv
// Shared types and constants for the accumulator address controller.
// The delay-line record is {read_en, read_addr, first_pass, last_pass}.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ACC_LAT_DEF = 2;

  function automatic int dl_width(input int addr_bit);
    return 2 + addr_bit + 1;
  endfunction

endpackage

// File: rtl/acc_addr_ctrl_if.sv
// Bus between the conv-engine side (master) and the address controller (slave).
// Carries the layer configuration, the valid stream and the accumulator-bank controls.
interface acc_addr_ctrl_if #(
  parameter int ADDR_BIT = 14,
  parameter int PASS_BIT = 10
);
  logic                start;
  logic [ADDR_BIT-1:0] pixel_num;
  logic [PASS_BIT-1:0] pass_num;
  logic                data_valid;

  logic                in_ready;
  logic                busy;
  logic                read_en;
  logic [ADDR_BIT-1:0] read_addr;
  logic                write_en;
  logic [ADDR_BIT-1:0] write_addr;
  logic                prev_data_zero;
  logic                curr_data_zero;
  logic                result_valid;
  logic [ADDR_BIT-1:0] result_addr;
  logic                done;
  logic                cfg_err;

  modport master (
    output start, pixel_num, pass_num, data_valid,
    input  in_ready, busy, read_en, read_addr, write_en, write_addr,
           prev_data_zero, curr_data_zero, result_valid, result_addr, done, cfg_err
  );

  modport slave (
    input  start, pixel_num, pass_num, data_valid,
    output in_ready, busy, read_en, read_addr, write_en, write_addr,
           prev_data_zero, curr_data_zero, result_valid, result_addr, done, cfg_err
  );
endinterface

// File: rtl/acc_ctrl_delay_line.sv
// Fixed-latency shift register that aligns read-side controls with the
// accumulator bank's write port.
module acc_ctrl_delay_line #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/acc_addr_ctrl.sv
// Sequences reads/writes of the partial-sum accumulator bank: one read per
// accepted pixel, writes ACC_LAT cycles later, with first/last-pass flags.
module acc_addr_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int ADDR_BIT = 14,
  parameter int PASS_BIT = 10,
  parameter int ACC_LAT  = ACC_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  acc_addr_ctrl_if.slave   bus
);

  localparam int DLW = dl_width(ADDR_BIT);
  localparam int DCW = $clog2(ACC_LAT + 2);

  state_t              r_state, w_state_next;
  logic [ADDR_BIT-1:0] r_pix_num, w_pix_num_next;
  logic [PASS_BIT-1:0] r_pass_num, w_pass_num_next;
  logic [ADDR_BIT-1:0] r_pix_cnt, w_pix_cnt_next;
  logic [PASS_BIT-1:0] r_pass_cnt, w_pass_cnt_next;
  logic [DCW-1:0]      r_drain_cnt, w_drain_cnt_next;
  logic                r_read_en, w_read_en_next;
  logic [ADDR_BIT-1:0] r_read_addr, w_read_addr_next;
  logic                r_first, w_first_next;
  logic                r_last, w_last_next;
  logic                r_done, w_done_next;
  logic                r_cfg_err, w_cfg_err_next;

  logic                w_cfg_ok;
  logic                w_last_pix;
  logic                w_last_pass;
  logic [DLW-1:0]      w_dl_in, w_dl_out;
  logic                w_wr_en, w_wr_first, w_wr_last;
  logic [ADDR_BIT-1:0] w_wr_addr;

  // pixel_num must exceed the bank latency so a pixel's write lands before
  // the next pass reads the same address.
  assign w_cfg_ok    = (int'(bus.pixel_num) > ACC_LAT) && (bus.pass_num != '0);
  assign w_last_pix  = (r_pix_cnt == r_pix_num - ADDR_BIT'(1));
  assign w_last_pass = (r_pass_cnt == r_pass_num - PASS_BIT'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pix_num   <= '0;
      r_pass_num  <= '0;
      r_pix_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_drain_cnt <= '0;
      r_read_en   <= 1'b0;
      r_read_addr <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pix_num   <= w_pix_num_next;
      r_pass_num  <= w_pass_num_next;
      r_pix_cnt   <= w_pix_cnt_next;
      r_pass_cnt  <= w_pass_cnt_next;
      r_drain_cnt <= w_drain_cnt_next;
      r_read_en   <= w_read_en_next;
      r_read_addr <= w_read_addr_next;
      r_first     <= w_first_next;
      r_last      <= w_last_next;
      r_done      <= w_done_next;
      r_cfg_err   <= w_cfg_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pix_num_next   = r_pix_num;
    w_pass_num_next  = r_pass_num;
    w_pix_cnt_next   = r_pix_cnt;
    w_pass_cnt_next  = r_pass_cnt;
    w_drain_cnt_next = r_drain_cnt;
    w_read_en_next   = 1'b0;
    w_read_addr_next = r_read_addr;
    w_first_next     = r_first;
    w_last_next      = r_last;
    w_done_next      = 1'b0;
    w_cfg_err_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_cfg_ok) begin
            w_state_next    = RUN;
            w_pix_num_next  = bus.pixel_num;
            w_pass_num_next = bus.pass_num;
            w_pix_cnt_next  = '0;
            w_pass_cnt_next = '0;
          end else begin
            w_cfg_err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.data_valid) begin
          w_read_en_next   = 1'b1;
          w_read_addr_next = r_pix_cnt;
          w_first_next     = (r_pass_cnt == '0);
          w_last_next      = w_last_pass;
          if (w_last_pix) begin
            w_pix_cnt_next = '0;
            if (w_last_pass) begin
              w_state_next     = DRAIN;
              w_drain_cnt_next = '0;
            end else begin
              w_pass_cnt_next = r_pass_cnt + PASS_BIT'(1);
            end
          end else begin
            w_pix_cnt_next = r_pix_cnt + ADDR_BIT'(1);
          end
        end
      end
      DRAIN: begin
        // Counts out the pipeline so done lands one cycle after the last write.
        if (r_drain_cnt == DCW'(ACC_LAT)) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_drain_cnt_next = r_drain_cnt + DCW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_dl_in = {r_read_en, r_read_addr, r_first, r_last};

  acc_ctrl_delay_line #(
    .WIDTH (DLW),
    .DEPTH (ACC_LAT)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_dl_in),
    .o_q   (w_dl_out)
  );

  assign {w_wr_en, w_wr_addr, w_wr_first, w_wr_last} = w_dl_out;

  assign bus.in_ready       = (r_state == RUN);
  assign bus.busy           = (r_state != IDLE);
  assign bus.read_en        = r_read_en;
  assign bus.read_addr      = r_read_addr;
  assign bus.write_en       = w_wr_en;
  assign bus.write_addr     = w_wr_addr;
  assign bus.prev_data_zero = w_wr_en & w_wr_first;
  assign bus.curr_data_zero = ~w_wr_en;
  assign bus.result_valid   = w_wr_en & w_wr_last;
  assign bus.result_addr    = w_wr_addr;
  assign bus.done           = r_done;
  assign bus.cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_acc_addr_ctrl.sv
// Directed, table-driven bench for acc_addr_ctrl: a per-cycle monitor checks
// read/write sequencing, and each layer's totals are compared against the table.
module tb_acc_addr_ctrl;

  localparam int AB  = 14;
  localparam int PB  = 10;
  localparam int LAT = 2;

  logic clk;
  logic rst_n;

  acc_addr_ctrl_if #(.ADDR_BIT(AB), .PASS_BIT(PB)) ifc ();

  acc_addr_ctrl #(.ADDR_BIT(AB), .PASS_BIT(PB), .ACC_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor state (written only by the monitor) and scenario context.
  int   cyc = 0;
  logic prev_acc = 1'b0;
  int   n_reads = 0, n_writes = 0, n_pdz = 0, n_rv = 0;
  int   done_cnt = 0, cfg_cnt = 0, busy_seen = 0;
  int   last_wr_cyc = 0, done_cyc = 0;
  int   rd_cyc[$];
  bit   mon_en = 1'b0;
  int   cur_pix = 1, cur_pass = 1, rd_base = 0, wr_base = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      chk("read_en_vs_accept", ifc.read_en, prev_acc);
      if (ifc.read_en) begin
        chk("read_addr", ifc.read_addr, (n_reads - rd_base) % cur_pix);
        rd_cyc.push_back(cyc);
        n_reads++;
      end
      chk("curr_data_zero", ifc.curr_data_zero, !ifc.write_en);
      if (ifc.write_en) begin
        int k, ri;
        k  = n_writes - wr_base;
        ri = rd_base + k;
        chk("write_addr", ifc.write_addr, k % cur_pix);
        chk("result_addr", ifc.result_addr, k % cur_pix);
        chk("prev_data_zero", ifc.prev_data_zero, k < cur_pix);
        chk("result_valid", ifc.result_valid, k >= cur_pix * (cur_pass - 1));
        if (ri < rd_cyc.size()) begin
          chk("write_latency", cyc - rd_cyc[ri], LAT);
        end else begin
          n_checks++;
          n_errors++;
          $display("FAIL write_without_read write_index=%0d reads=%0d", k, rd_cyc.size() - rd_base);
        end
        if (ifc.prev_data_zero) n_pdz++;
        if (ifc.result_valid) n_rv++;
        last_wr_cyc = cyc;
        n_writes++;
      end else begin
        chk("flags_idle", {ifc.prev_data_zero, ifc.result_valid}, 0);
      end
      if (ifc.done) begin
        chk("busy_at_done", ifc.busy, 0);
        done_cnt++;
        done_cyc = cyc;
      end
      if (ifc.cfg_err) cfg_cnt++;
      if (ifc.busy) busy_seen++;
    end
    prev_acc = ifc.in_ready & ifc.data_valid;
  end

  typedef struct {
    int pix;
    int pass;
    int mode;       // 0: valid held, 1: valid toggling, 2: held + mid-run start
    bit exp_cfg;
    int exp_writes;
    int exp_pdz;
    int exp_rv;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic run_case(input int idx, input vec_t v);
    int b_w, b_pdz, b_rv, b_done, b_cfg, b_busy, t;
    cur_pix  = v.pix;
    cur_pass = v.pass;
    rd_base  = n_reads;
    wr_base  = n_writes;
    b_w = n_writes; b_pdz = n_pdz; b_rv = n_rv;
    b_done = done_cnt; b_cfg = cfg_cnt; b_busy = busy_seen;
    @(posedge clk); #1;
    ifc.start      = 1'b1;
    ifc.pixel_num  = AB'(v.pix);
    ifc.pass_num   = PB'(v.pass);
    ifc.data_valid = 1'b0;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk($sformatf("v%0d_busy_after_start", idx), ifc.busy, !v.exp_cfg);
    chk($sformatf("v%0d_in_ready_after_start", idx), ifc.in_ready, !v.exp_cfg);
    t = 0;
    if (!v.exp_cfg) begin
      while (done_cnt == b_done && t < 3000) begin
        case (v.mode)
          1:       ifc.data_valid = (t % 2 == 0);
          2: begin
            ifc.data_valid = 1'b1;
            ifc.start      = (t == 4);
            ifc.pixel_num  = AB'(3);
            ifc.pass_num   = PB'(1);
          end
          default: ifc.data_valid = 1'b1;
        endcase
        @(posedge clk); #1;
        t++;
      end
      ifc.start = 1'b0;
      chk($sformatf("v%0d_no_timeout", idx), t < 3000, 1);
    end else begin
      ifc.data_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
    end
    ifc.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_writes", idx), n_writes - b_w, v.exp_writes);
    chk($sformatf("v%0d_prev_zero_count", idx), n_pdz - b_pdz, v.exp_pdz);
    chk($sformatf("v%0d_result_count", idx), n_rv - b_rv, v.exp_rv);
    chk($sformatf("v%0d_cfg_err", idx), cfg_cnt - b_cfg, v.exp_cfg);
    chk($sformatf("v%0d_done", idx), done_cnt - b_done, v.exp_done);
    chk($sformatf("v%0d_busy_seen", idx), busy_seen - b_busy > 0, !v.exp_cfg);
    if (v.exp_done != 0)
      chk($sformatf("v%0d_done_delay", idx), done_cyc - last_wr_cyc, 1);
    $display("vec %0d pix=%0d pass=%0d mode=%0d writes=%0d done=%0d cfg_err=%0d",
             idx, v.pix, v.pass, v.mode, n_writes - b_w, done_cnt - b_done, cfg_cnt - b_cfg);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctl"},
        {ifc.busy, ifc.in_ready, ifc.read_en, ifc.write_en, ifc.prev_data_zero,
         ifc.curr_data_zero, ifc.result_valid, ifc.done, ifc.cfg_err}, 9'b000001000);
    chk({name, "_addr"}, {ifc.read_addr, ifc.write_addr, ifc.result_addr}, 0);
  endtask

  initial begin
    int d;
    vecs[0] = '{pix: 4,   pass: 2, mode: 0, exp_cfg: 0, exp_writes: 8,   exp_pdz: 4,   exp_rv: 4,   exp_done: 1};
    vecs[1] = '{pix: 4,   pass: 2, mode: 1, exp_cfg: 0, exp_writes: 8,   exp_pdz: 4,   exp_rv: 4,   exp_done: 1};
    vecs[2] = '{pix: 2,   pass: 2, mode: 0, exp_cfg: 1, exp_writes: 0,   exp_pdz: 0,   exp_rv: 0,   exp_done: 0};
    vecs[3] = '{pix: 5,   pass: 0, mode: 0, exp_cfg: 1, exp_writes: 0,   exp_pdz: 0,   exp_rv: 0,   exp_done: 0};
    vecs[4] = '{pix: 169, pass: 1, mode: 0, exp_cfg: 0, exp_writes: 169, exp_pdz: 169, exp_rv: 169, exp_done: 1};
    vecs[5] = '{pix: 6,   pass: 3, mode: 2, exp_cfg: 0, exp_writes: 18,  exp_pdz: 6,   exp_rv: 6,   exp_done: 1};
    vecs[6] = '{pix: 3,   pass: 1, mode: 0, exp_cfg: 0, exp_writes: 3,   exp_pdz: 3,   exp_rv: 3,   exp_done: 1};

    rst_n          = 1'b0;
    ifc.start      = 1'b0;
    ifc.pixel_num  = '0;
    ifc.pass_num   = '0;
    ifc.data_valid = 1'b0;
    #2;
    chk_reset_outputs("reset_initial");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Abandon a layer at pixel 5 of the second pass with an asynchronous reset.
    @(posedge clk); #1;
    ifc.start     = 1'b1;
    ifc.pixel_num = AB'(8);
    ifc.pass_num  = PB'(2);
    @(posedge clk); #1;
    ifc.start      = 1'b0;
    ifc.data_valid = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_reset_busy", ifc.busy, 1);
    chk("pre_reset_read_addr", ifc.read_addr, 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_run");
    ifc.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.done || ifc.write_en || ifc.busy) d++;
    end
    chk("no_activity_after_reset", d, 0);
    $display("reset sequence: layer abandoned at pass 1 pixel 5");

    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_case(i, vecs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acc_addr_ctrl.md
Name: acc_addr_ctrl

Overview:
- Sequencing controller that drives the shared control inputs of an 8-lane partial-sum accumulator bank: read/write enables, read/write addresses, and the two zero flags.
- Walks every output pixel once per input-channel pass, for all passes of a layer.
- Zeroes the old partial sum on the first pass.
- Flags final sums on the last pass so the post-processing stage can capture them.
- Sits between the conv-engine valid stream and the accumulator bank.

Parameters:
- ADDR_BIT, 14, width of the pixel address (buffer depth up to 2^ADDR_BIT).
- PASS_BIT, 10, width of the pass counter.
- ACC_LAT, 2, cycles from read_en/read_addr to the matching write_en/write_addr inside the accumulator bank (≥1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches pixel_num/pass_num and begins a layer
- pixel_num  input  ADDR_BIT  pixels per pass, sampled at start
- pass_num  input  PASS_BIT  input-channel passes per layer, sampled at start
- data_valid  input  1  conv engine presents one pixel's 8 partial products this cycle
- in_ready  output  1  high in RUN; data_valid is consumed only when in_ready=1
- busy  output  1  high from the accepted start until done
- read_en  output  1  accumulator read strobe
- read_addr  output  ADDR_BIT  accumulator read address
- write_en  output  1  accumulator write strobe
- write_addr  output  ADDR_BIT  accumulator write address
- prev_data_zero  output  1  ignore the stored sum (first pass); aligned with write_en
- curr_data_zero  output  1  ignore the current data; equals ~write_en
- result_valid  output  1  final sum is on acc_result this cycle (last-pass write)
- result_addr  output  ADDR_BIT  pixel index of the final sum
- done  output  1  one-cycle pulse at layer end
- cfg_err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Clock and reset: one clock domain.
- Reset values: on rst_n=0, immediately and asynchronously:
  - state=IDLE, all counters and delay-line contents 0.
  - All outputs 0, except curr_data_zero=1.
  - Reset mid-layer abandons the layer; no done pulse.
- State machine:
  - IDLE: start=1 with pixel_num>ACC_LAT and pass_num≠0 → RUN, busy=1. Otherwise start causes a cfg_err pulse the next cycle and the block stays IDLE. The pixel_num>ACC_LAT limit prevents read-before-write of the same address across passes.
  - RUN: each cycle with data_valid=1:
    - read_en=1, read_addr=pix_cnt (registered outputs, valid the cycle after data_valid).
    - pix_cnt increments; at pixel_num-1 it wraps to 0 and pass_cnt increments.
    - After the read of pixel pixel_num-1 in pass pass_num-1 → DRAIN.
    - data_valid=0 stalls both counters and sets read_en=0; the delay line keeps shifting, inserting bubbles.
  - DRAIN: in_ready=0. Waits ACC_LAT cycles until the delay line is empty, then pulses done and returns to IDLE with busy=0. done is asserted the cycle after the last write_en.
- Delay line: {read_en, read_addr, first_pass, last_pass} delayed by exactly ACC_LAT cycles, producing:
  - write_en, write_addr
  - prev_data_zero = write_en & first_pass
  - result_valid = write_en & last_pass
  - result_addr = write_addr
- Single-pass layer (pass_num=1): prev_data_zero and result_valid are both asserted on every write.
- Ignored inputs:
  - start while busy: ignored, no cfg_err.
  - data_valid in IDLE or DRAIN: ignored.
- Counter widths: pix_cnt is ADDR_BIT bits; pass_cnt is PASS_BIT bits; no overflow is possible given the start checks.

Decomposition:
- Package acc_ctrl_pkg holds:
  - state encoding IDLE/RUN/DRAIN (2 bits)
  - ACC_LAT default constant
  - packed delay-line record width (2+ADDR_BIT+1)
- One sub-module: acc_ctrl_delay_line, a parameterised shift register (WIDTH, DEPTH=ACC_LAT) with asynchronous active-low reset to 0.

Test Plan:
- Reset during RUN at pixel 5 of pass 1 → all outputs 0 (curr_data_zero=1) in the same cycle; no done; a subsequent start runs cleanly.
- pixel_num=4, pass_num=2, data_valid held 1 → 8 reads at addresses 0,1,2,3,0,1,2,3.
  - Writes mirror the reads 2 cycles later.
  - prev_data_zero=1 on the first 4 writes; result_valid=1 on the last 4 writes with result_addr 0..3.
  - done pulses one cycle after the 8th write.
- Same configuration with data_valid toggling 1,0,1,0 → counters advance only on valid cycles; write_en shows matching bubbles; total of 8 writes; addresses unchanged.
- pixel_num=2 (≤ACC_LAT) or pass_num=0 → cfg_err pulse; busy stays 0; no read_en.
- pixel_num=169, pass_num=1 → 169 writes, each with prev_data_zero=1 and result_valid=1; done after the write to address 168.
- start pulse in mid-RUN and data_valid during DRAIN → no change to counters or outputs; exactly pixel_num*pass_num writes in total.
